// File: rtl/run_length_detector.sv
// Flags runs of RUN_LEN or more consecutive accepted bits equal to a run-time target.
// Optional detection-event counter built only when DET_COUNT_EN is defined.
module run_length_detector #(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         x,
  input  logic                         target,
  input  logic                         overlap,
  input  logic                         clear,
  output logic                         y,
  output logic [$clog2(RUN_LEN+1)-1:0] run_cnt,
  output logic [CNT_W-1:0]             det_cnt
);

  localparam int RW = $clog2(RUN_LEN + 1);
  localparam logic [RW-1:0] LEN_R = RW'(RUN_LEN);
  localparam logic [RW:0]   LEN_X = (RW + 1)'(RUN_LEN);

  typedef enum logic [1:0] {IDLE, ACC, HIT} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic          y_q, y_d;
  logic          overlap_q, target_q;
  logic [RW:0]   run_inc;
  logic          match, cfg_chg;

  assign match   = in_valid & (x == target);
  assign cfg_chg = (target != target_q) | (overlap != overlap_q);
  // One extra bit so run_q+1 never wraps when run_q == RUN_LEN
  assign run_inc = {1'b0, run_q} + {{RW{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      run_q     <= '0;
      y_q       <= 1'b0;
      overlap_q <= 1'b0;
      target_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      y_q       <= y_d;
      overlap_q <= overlap;
      target_q  <= target;
    end
  end

  always_comb begin
    run_d = run_q;
    y_d   = 1'b0;
    if (clear || cfg_chg) begin
      run_d = '0;
    end else if (in_valid) begin
      if (!match) begin
        run_d = '0;
      end else if (overlap) begin
        // HIT saturates: run stays at RUN_LEN and every further match re-fires
        if (state_q == HIT) begin
          run_d = LEN_R;
          y_d   = 1'b1;
        end else begin
          run_d = run_inc[RW-1:0];
          y_d   = (run_inc >= LEN_X);
        end
      end else if (run_inc >= LEN_X) begin
        run_d = '0;
        y_d   = 1'b1;
      end else begin
        run_d = run_inc[RW-1:0];
      end
    end
    if (run_d == '0)
      state_d = IDLE;
    else if (run_d == LEN_R)
      state_d = HIT;
    else
      state_d = ACC;
  end

`ifdef DET_COUNT_EN
  logic [CNT_W-1:0] det_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      det_q <= '0;
    else if (clear)
      det_q <= '0;
    else if (y_d && (det_q != {CNT_W{1'b1}}))
      det_q <= det_q + CNT_W'(1);
  end
`else
  logic [CNT_W-1:0] det_q;
  assign det_q = '0;
`endif

  always_comb begin
    y       = y_q;
    run_cnt = run_q;
    det_cnt = det_q;
  end

endmodule

// File: tb/tb_run_length_detector.sv
// Directed bench for run_length_detector: two instances (RUN_LEN=2/CNT_W=2 and RUN_LEN=3)
// share stimulus; each scenario checks only the instance it targets.
module tb_run_length_detector;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, x, target, overlap, clear;
  logic       y2, y3;
  logic [1:0] run2, run3;
  logic [1:0] det2;
  logic [7:0] det3;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  run_length_detector #(.RUN_LEN(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .target(target),
    .overlap(overlap), .clear(clear), .y(y2), .run_cnt(run2), .det_cnt(det2)
  );

  run_length_detector #(.RUN_LEN(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .target(target),
    .overlap(overlap), .clear(clear), .y(y3), .run_cnt(run3), .det_cnt(det3)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected det_cnt for a 2-bit counter after n detection events
  function automatic int exp_det(input int n);
`ifdef DET_COUNT_EN
    return (n > 3) ? 3 : n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic step(input logic v, input logic xv);
    in_valid = v;
    x        = xv;
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk2(input logic xv, input int ey, input int er, input string tag);
    step(1'b1, xv);
    check({tag, ".y"}, y2, ey);
    check({tag, ".run"}, run2, er);
  endtask

  task automatic step_chk3(input logic v, input logic xv, input int ey, input int er,
                           input string tag);
    step(v, xv);
    check({tag, ".y"}, y3, ey);
    check({tag, ".run"}, run3, er);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; x = 1'b0; target = 1'b0; overlap = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.y", y2, 0);
    check("rst.run", run2, 0);
    check("rst.det", det2, 0);
    rst_n = 1'b1;

    // 1: RUN_LEN=2 overlapping, target 0
    overlap = 1'b1; target = 1'b0;
    step(1'b0, 1'b0);
    step_chk2(1'b1, 0, 0, "t1.0");
    step_chk2(1'b0, 0, 1, "t1.1");
    step_chk2(1'b0, 1, 2, "t1.2");
    step_chk2(1'b0, 1, 2, "t1.3");
    step_chk2(1'b1, 0, 0, "t1.4");

    // 2: non-overlapping, run restarts after each detection
    overlap = 1'b0;
    step(1'b0, 1'b0);
    check("t2.cfg.run", run2, 0);
    step_chk2(1'b0, 0, 1, "t2.0");
    step_chk2(1'b0, 1, 0, "t2.1");
    step_chk2(1'b0, 0, 1, "t2.2");
    step_chk2(1'b0, 1, 0, "t2.3");
    step_chk2(1'b0, 0, 1, "t2.4");
    check("t2.det", det2, exp_det(4));

    // 3: RUN_LEN=3, target 1, run holds across in_valid gaps
    overlap = 1'b1; target = 1'b1;
    step(1'b0, 1'b0);
    step_chk3(1'b1, 1'b1, 0, 1, "t3.0");
    step_chk3(1'b0, 1'b1, 0, 1, "t3.gap0");
    step_chk3(1'b0, 1'b0, 0, 1, "t3.gap1");
    step_chk3(1'b1, 1'b1, 0, 2, "t3.1");
    step_chk3(1'b1, 1'b1, 1, 3, "t3.2");

    // 4: async reset mid-run loses all progress
    step_chk3(1'b1, 1'b0, 0, 0, "t4.pre0");
    step_chk3(1'b1, 1'b1, 0, 1, "t4.pre1");
    step_chk3(1'b1, 1'b1, 0, 2, "t4.pre2");
    rst_n = 1'b0;
    #1;
    check("t4.rst.y", y3, 0);
    check("t4.rst.run", run3, 0);
    check("t4.rst.det", det3, 0);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    step_chk3(1'b1, 1'b1, 0, 1, "t4.post0");
    step_chk3(1'b1, 1'b1, 0, 2, "t4.post1");

    // 5: config change discards the sample and zeroes the run
    target = 1'b0; overlap = 1'b1;
    step(1'b0, 1'b0);
    step_chk2(1'b0, 0, 1, "t5.a0");
    target = 1'b1;
    step_chk2(1'b1, 0, 0, "t5.flip");
    step_chk2(1'b1, 0, 1, "t5.a1");
    step_chk2(1'b1, 1, 2, "t5.a2");
    step_chk2(1'b0, 0, 0, "t5.b0");
    step_chk2(1'b1, 0, 1, "t5.b1");
    overlap = 1'b0;
    step_chk2(1'b1, 0, 0, "t5.ovl");
    step_chk2(1'b1, 0, 1, "t5.b2");
    step_chk2(1'b1, 1, 0, "t5.b3");

    // 6: clear flushes, then five detections saturate the 2-bit counter
    clear = 1'b1;
    step_chk2(1'b1, 0, 0, "t6.clr0");
    clear = 1'b0;
    check("t6.det0", det2, 0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    check("t6.y", y2, 1);
    check("t6.det5", det2, exp_det(5));
    clear = 1'b1;
    step(1'b1, 1'b1);
    clear = 1'b0;
    check("t6.clr1.det", det2, 0);
    check("t6.clr1.y", y2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
